// File: rtl/debounce_pkg.sv
// Shared types and width helpers for the button debouncer bank.
package debounce_pkg;

   // Per-channel hold/repeat state machine encoding
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DELAY  = 2'd1,
      REPEAT = 2'd2
   } rpt_state_t;

   // Bits needed to count 0 .. n-1, never less than one bit
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // Larger of two cycle counts
   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-FF synchroniser, stability filter, edge pulses and
// hold-to-repeat / long-press state machine.
module debounce_channel
   import debounce_pkg::*;
#(
   parameter bit          ACTIVE_LOW      = 1'b0,
   parameter int unsigned DEBOUNCE_CYCLES = 36000,
   parameter int unsigned REPEAT_DELAY    = 18000000,
   parameter int unsigned REPEAT_PERIOD   = 3600000
) (
   input  logic clk,
   input  logic arst,
   input  logic sw_i,
   input  logic repeat_en_i,
   output logic sw_state_o,
   output logic sw_down_o,
   output logic sw_up_o,
   output logic sw_repeat_o,
   output logic sw_long_o
);

   localparam int unsigned DB_W = cnt_width(DEBOUNCE_CYCLES);
   localparam int unsigned T_W  = cnt_width(max_u(REPEAT_DELAY, REPEAT_PERIOD));
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [T_W-1:0]  RD_LAST = T_W'(REPEAT_DELAY - 1);
   localparam logic [T_W-1:0]  RP_LAST = T_W'(REPEAT_PERIOD - 1);
   localparam logic            IDLE_LVL = ACTIVE_LOW;

   logic [1:0]      r_sync;
   logic            r_p;
   logic            r_state;
   logic [DB_W-1:0] r_cnt;
   logic            r_down;
   logic            r_up;
   rpt_state_t      r_fsm;
   logic [T_W-1:0]  r_t;
   logic            r_rpt;
   logic            r_long;

   logic            w_diff;
   logic            w_hit;
   logic            w_press;
   logic            w_rel;

   // Debounced level flips when the input has differed for the full window
   assign w_diff  = r_p ^ r_state;
   assign w_hit   = w_diff && (r_cnt == DB_LAST);
   assign w_press = w_hit & ~r_state;
   assign w_rel   = w_hit &  r_state;

   // Synchronise the pad and register the pressed polarity (p)
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         r_sync <= {2{IDLE_LVL}};
         r_p    <= 1'b0;
      end else begin
         r_sync <= {r_sync[0], sw_i};
         r_p    <= r_sync[1] ^ ACTIVE_LOW;
      end
   end

   // Stability counter, debounced level and one-cycle edge pulses
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         r_state <= 1'b0;
         r_cnt   <= '0;
         r_down  <= 1'b0;
         r_up    <= 1'b0;
      end else begin
         r_down <= w_press;
         r_up   <= w_rel;
         if (!w_diff) begin
            r_cnt <= '0;
         end else if (w_hit) begin
            r_state <= ~r_state;
            r_cnt   <= '0;
         end else begin
            r_cnt <= r_cnt + DB_W'(1);
         end
      end
   end

   // Repeat FSM; long-press flag drops the cycle after the up pulse
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         r_fsm  <= IDLE;
         r_t    <= '0;
         r_rpt  <= 1'b0;
         r_long <= 1'b0;
      end else begin
         r_rpt <= 1'b0;
         if (r_up) begin
            r_long <= 1'b0;
         end
         case (r_fsm)
            IDLE: begin
               if (w_press) begin
                  r_fsm <= DELAY;
                  r_t   <= '0;
                  r_rpt <= 1'b1;
               end
            end
            DELAY: begin
               if (w_rel) begin
                  r_fsm <= IDLE;
                  r_t   <= '0;
               end else if (r_t == RD_LAST) begin
                  r_fsm  <= REPEAT;
                  r_t    <= '0;
                  r_rpt  <= repeat_en_i;
                  r_long <= 1'b1;
               end else begin
                  r_t <= r_t + T_W'(1);
               end
            end
            REPEAT: begin
               if (w_rel) begin
                  r_fsm <= IDLE;
                  r_t   <= '0;
               end else if (r_t == RP_LAST) begin
                  r_t   <= '0;
                  r_rpt <= repeat_en_i;
               end else begin
                  r_t <= r_t + T_W'(1);
               end
            end
            default: begin
               r_fsm <= IDLE;
               r_t   <= '0;
            end
         endcase
      end
   end

   assign sw_state_o  = r_state;
   assign sw_down_o   = r_down;
   assign sw_up_o     = r_up;
   assign sw_repeat_o = r_rpt;
   assign sw_long_o   = r_long;

endmodule

// File: rtl/button_debouncer_bank.sv
// Bank of independent button debouncers with edge, repeat and long-press outputs.
module button_debouncer_bank
   import debounce_pkg::*;
#(
   parameter int unsigned N_CH            = 5,
   parameter bit          ACTIVE_LOW      = 1'b0,
   parameter int unsigned DEBOUNCE_CYCLES = 36000,
   parameter int unsigned REPEAT_DELAY    = 18000000,
   parameter int unsigned REPEAT_PERIOD   = 3600000
) (
   input  logic            clk,
   input  logic            arst,
   input  logic [N_CH-1:0] sw_i,
   input  logic [N_CH-1:0] repeat_en_i,
   output logic [N_CH-1:0] sw_state_o,
   output logic [N_CH-1:0] sw_down_o,
   output logic [N_CH-1:0] sw_up_o,
   output logic [N_CH-1:0] sw_repeat_o,
   output logic [N_CH-1:0] sw_long_o
);

   // Reject zero-valued parameters at elaboration
   if (N_CH == 0) begin : g_bad_n_ch
      $error("button_debouncer_bank: N_CH must be >= 1");
   end
   if (DEBOUNCE_CYCLES == 0) begin : g_bad_debounce
      $error("button_debouncer_bank: DEBOUNCE_CYCLES must be >= 1");
   end
   if (REPEAT_DELAY == 0) begin : g_bad_delay
      $error("button_debouncer_bank: REPEAT_DELAY must be >= 1");
   end
   if (REPEAT_PERIOD == 0) begin : g_bad_period
      $error("button_debouncer_bank: REPEAT_PERIOD must be >= 1");
   end

   // One self-contained channel per button
   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      debounce_channel #(
         .ACTIVE_LOW      (ACTIVE_LOW),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_PERIOD   (REPEAT_PERIOD)
      ) u_ch (
         .clk         (clk),
         .arst        (arst),
         .sw_i        (sw_i[g]),
         .repeat_en_i (repeat_en_i[g]),
         .sw_state_o  (sw_state_o[g]),
         .sw_down_o   (sw_down_o[g]),
         .sw_up_o     (sw_up_o[g]),
         .sw_repeat_o (sw_repeat_o[g]),
         .sw_long_o   (sw_long_o[g])
      );
   end

endmodule

// File: tb/tb_button_debouncer_bank.sv
// Directed bench for button_debouncer_bank: DEBOUNCE=4, DELAY=20, PERIOD=8.
// A pad value driven mid-cycle is sampled at the next edge (edge 0); the
// debounced level and edge pulses then move at edge 6.
module tb_button_debouncer_bank;

   logic       clk = 1'b0;
   logic       arst0, arst1;
   logic [4:0] sw0, en0, st0, dn0, up0, rp0, lg0;
   logic [4:0] sw1, en1, st1, dn1, up1, rp1, lg1;
   logic [4:0] e_st, e_dn, e_up, e_rp, e_lg;
   int         n_cmp = 0;
   int         n_bad = 0;

   always #5 clk = ~clk;

   button_debouncer_bank #(
      .N_CH(5), .ACTIVE_LOW(1'b0), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(8)
   ) u_dut (
      .clk(clk), .arst(arst0), .sw_i(sw0), .repeat_en_i(en0),
      .sw_state_o(st0), .sw_down_o(dn0), .sw_up_o(up0), .sw_repeat_o(rp0), .sw_long_o(lg0)
   );

   button_debouncer_bank #(
      .N_CH(5), .ACTIVE_LOW(1'b1), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(8)
   ) u_dut_al (
      .clk(clk), .arst(arst1), .sw_i(sw1), .repeat_en_i(en1),
      .sw_state_o(st1), .sw_down_o(dn1), .sw_up_o(up1), .sw_repeat_o(rp1), .sw_long_o(lg1)
   );

   task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk_all0(input string tag);
      chk({tag, ".state"},  st0, 5'b0);
      chk({tag, ".down"},   dn0, 5'b0);
      chk({tag, ".up"},     up0, 5'b0);
      chk({tag, ".repeat"}, rp0, 5'b0);
      chk({tag, ".long"},   lg0, 5'b0);
   endtask

   task automatic chk_all1(input string tag);
      chk({tag, ".state"},  st1, 5'b0);
      chk({tag, ".down"},   dn1, 5'b0);
      chk({tag, ".up"},     up1, 5'b0);
      chk({tag, ".repeat"}, rp1, 5'b0);
      chk({tag, ".long"},   lg1, 5'b0);
   endtask

   // 60-cycle hold of ch1 on the active-high bank; k counts edges after the down pulse
   task automatic hold_ch1(input string tag, input bit rpt_on);
      en0    = rpt_on ? 5'b00010 : 5'b00000;
      sw0[1] = 1'b1;
      step(6);
      chk({tag, ".pre_down"}, dn0, 5'b0);
      step(1);
      chk({tag, ".down"},   dn0, 5'b00010);
      chk({tag, ".press"},  rp0, 5'b00010);
      chk({tag, ".state"},  st0, 5'b00010);
      for (int k = 1; k <= 62; k++) begin
         if (k == 54) sw0[1] = 1'b0;
         step(1);
         e_rp = (rpt_on && (k == 20 || k == 28 || k == 36 || k == 44 || k == 52)) ? 5'b00010 : 5'b0;
         e_lg = (k >= 20 && k <= 60) ? 5'b00010 : 5'b0;
         e_up = (k == 60) ? 5'b00010 : 5'b0;
         e_st = (k < 60) ? 5'b00010 : 5'b0;
         chk($sformatf("%s.repeat@%0d", tag, k), rp0, e_rp);
         chk($sformatf("%s.long@%0d",   tag, k), lg0, e_lg);
         chk($sformatf("%s.up@%0d",     tag, k), up0, e_up);
         chk($sformatf("%s.state@%0d",  tag, k), st0, e_st);
      end
   endtask

   initial begin
      arst0 = 1'b1;
      arst1 = 1'b1;
      sw0   = 5'b11111;
      sw1   = 5'b11111;
      en0   = 5'b00000;
      en1   = 5'b11111;
      e_st = '0; e_dn = '0; e_up = '0; e_rp = '0; e_lg = '0;

      // Reset held with every pad pressed
      step(3);
      chk_all0("rst0");
      chk_all1("rst1");

      // Release reset: all channels register a press at edge 6
      arst0 = 1'b0;
      step(6);
      chk("rst_rel.state_early", st0, 5'b00000);
      chk("rst_rel.down_early",  dn0, 5'b00000);
      step(1);
      chk("rst_rel.state",  st0, 5'b11111);
      chk("rst_rel.down",   dn0, 5'b11111);
      chk("rst_rel.repeat", rp0, 5'b11111);
      step(1);
      chk("rst_rel.down_1cyc",   dn0, 5'b00000);
      chk("rst_rel.repeat_1cyc", rp0, 5'b00000);
      chk("rst_rel.state_hold",  st0, 5'b11111);

      // Release all: up pulse at edge 6, no repeat
      sw0 = 5'b00000;
      step(6);
      chk("rel_all.state_early", st0, 5'b11111);
      chk("rel_all.up_early",    up0, 5'b00000);
      step(1);
      chk("rel_all.state",  st0, 5'b00000);
      chk("rel_all.up",     up0, 5'b11111);
      chk("rel_all.down",   dn0, 5'b00000);
      chk("rel_all.repeat", rp0, 5'b00000);
      step(1);
      chk("rel_all.up_1cyc", up0, 5'b00000);
      step(4);
      chk_all0("quiet");

      // Bounce on ch0: 1-cycle high / 1-cycle low for 30 cycles
      for (int i = 0; i < 30; i++) begin
         sw0[0] = (i % 2 == 0);
         step(1);
         chk($sformatf("bounce.state@%0d", i), st0, 5'b0);
         chk($sformatf("bounce.down@%0d",  i), dn0, 5'b0);
      end
      sw0[0] = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step(1);
         chk($sformatf("bounce.settle_down@%0d", i), dn0, 5'b0);
      end
      step(1);
      chk("bounce.down",  dn0, 5'b00001);
      chk("bounce.state", st0, 5'b00001);
      sw0[0] = 1'b0;
      step(12);
      chk("bounce.released", st0, 5'b00000);

      // 3-cycle glitch on ch2 never reaches the outputs
      for (int i = 0; i < 14; i++) begin
         sw0[2] = (i < 3);
         step(1);
         chk($sformatf("glitch.state@%0d", i), st0, 5'b0);
         chk($sformatf("glitch.down@%0d",  i), dn0, 5'b0);
         chk($sformatf("glitch.up@%0d",    i), up0, 5'b0);
      end

      // Auto-repeat on ch1, then the same hold with repeat disabled
      hold_ch1("rpt_on", 1'b1);
      step(4);
      hold_ch1("rpt_off", 1'b0);
      step(4);
      chk_all0("after_hold");

      // Active-low bank: idle pads high, ch3 pressed by driving low
      arst1 = 1'b0;
      step(10);
      chk_all1("al_idle");
      sw1[3] = 1'b0;
      step(6);
      chk("al.down_early", dn1, 5'b0);
      step(1);
      chk("al.down",   dn1, 5'b01000);
      chk("al.state",  st1, 5'b01000);
      chk("al.repeat", rp1, 5'b01000);
      step(19);
      chk("al.long_before", lg1, 5'b00000);
      step(1);
      chk("al.long_rise",  lg1, 5'b01000);
      chk("al.first_rpt",  rp1, 5'b01000);
      step(4);
      chk("al.long_held",  lg1, 5'b01000);
      chk("al.state_held", st1, 5'b01000);

      // Mid-hold reset pulse: clears immediately, no up pulse afterwards
      arst1 = 1'b1;
      #1;
      chk_all1("al_arst_async");
      step(1);
      arst1 = 1'b0;
      chk_all1("al_arst_edge");
      for (int i = 0; i < 6; i++) begin
         step(1);
         chk($sformatf("al_rearm.state@%0d", i), st1, 5'b0);
         chk($sformatf("al_rearm.up@%0d",    i), up1, 5'b0);
         chk($sformatf("al_rearm.down@%0d",  i), dn1, 5'b0);
      end
      step(1);
      chk("al_rearm.down",   dn1, 5'b01000);
      chk("al_rearm.state",  st1, 5'b01000);
      chk("al_rearm.repeat", rp1, 5'b01000);
      chk("al_rearm.long",   lg1, 5'b00000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
